rggen_external_bus_bridge: RTL and testbench

Bridge on the external-register port of a generated register block. It accepts one request at a time from the block's external-register bus master, issues it on a valid/ready command channel to the attached peripheral, and waits for that peripheral's response. It then returns read data and status to the register block. A programmable timeout guarantees the register block always receives a completion, even when the peripheral hangs.

---
 rtl/rggen_external_bus_bridge_if.sv | 37 +++
 rtl/rggen_external_bus_bridge.sv | 83 ++++++++
 tb/tb_rggen_external_bus_bridge.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rggen_external_bus_bridge_if.sv
// rggen_external_bus_bridge_if: upstream register-bus and downstream command/response signals of the bridge
interface rggen_external_bus_bridge_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  logic                      i_bus_request;
  logic [ADDRESS_WIDTH-1:0]  i_bus_address;
  logic                      i_bus_write;
  logic [DATA_WIDTH-1:0]     i_bus_write_data;
  logic [DATA_WIDTH-1:0]     i_bus_write_mask;
  logic                      o_bus_done;
  logic [DATA_WIDTH-1:0]     o_bus_read_data;
  logic [1:0]                o_bus_status;
  logic                      o_ext_valid;
  logic                      i_ext_ready;
  logic [ADDRESS_WIDTH-1:0]  o_ext_address;
  logic                      o_ext_write;
  logic [DATA_WIDTH-1:0]     o_ext_write_data;
  logic [DATA_WIDTH/8-1:0]   o_ext_strobe;
  logic                      i_ext_resp_valid;
  logic [DATA_WIDTH-1:0]     i_ext_resp_data;
  logic                      i_ext_resp_error;
  logic                      o_busy;
  logic [7:0]                o_timeout_events;
  modport slave (
    input  i_bus_request, i_bus_address, i_bus_write, i_bus_write_data, i_bus_write_mask,
    input  i_ext_ready, i_ext_resp_valid, i_ext_resp_data, i_ext_resp_error,
    output o_bus_done, o_bus_read_data, o_bus_status, o_ext_valid, o_ext_address,
    output o_ext_write, o_ext_write_data, o_ext_strobe, o_busy, o_timeout_events
  );
  modport master (
    output i_bus_request, i_bus_address, i_bus_write, i_bus_write_data, i_bus_write_mask,
    output i_ext_ready, i_ext_resp_valid, i_ext_resp_data, i_ext_resp_error,
    input  o_bus_done, o_bus_read_data, o_bus_status, o_ext_valid, o_ext_address,
    input  o_ext_write, o_ext_write_data, o_ext_strobe, o_busy, o_timeout_events
  );
endinterface

// File: rtl/rggen_external_bus_bridge.sv
// rggen_external_bus_bridge: one-at-a-time register-bus to valid/ready command bridge with response timeout
module rggen_external_bus_bridge #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                    clk,
  input logic                    rst,
  rggen_external_bus_bridge_if.slave bus
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;
  state_t                   state, state_next;
  logic [CW-1:0]            count;
  logic [SW-1:0]            mask_strobe, strobe;
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     write;
  logic [DATA_WIDTH-1:0]    write_data, read_data;
  logic [1:0]               status;
  logic [7:0]               events;
  logic                     timeout, resp_hs, abort;
  for (genvar i = 0; i < SW; i++) begin : g_strobe
    assign mask_strobe[i] = |bus.i_bus_write_mask[8*i+:8];
  end
  // >= rather than == so a last-cycle command handshake followed by a hung response still aborts
  assign timeout = TIMEOUT_CYCLES != 0 && count >= LIM;
  assign resp_hs = state == RESP && bus.i_ext_resp_valid;
  assign abort   = timeout && ((state == CMD && !bus.i_ext_ready) || (state == RESP && !bus.i_ext_resp_valid));
  // state register
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_next;
  end
  // next-state decode
  always_comb begin
    state_next = state;
    if (state == IDLE && bus.i_bus_request) state_next = CMD;
    if (state == CMD && bus.i_ext_ready) state_next = RESP;
    if (resp_hs || abort || state == DONE) state_next = state == DONE ? IDLE : DONE;
  end
  // request capture, timeout counter and completion registers
  always_ff @(posedge clk) begin
    if (rst) begin
      address    <= '0;
      write      <= 1'b0;
      write_data <= '0;
      strobe     <= '0;
      count      <= '0;
      read_data  <= '0;
      status     <= 2'b00;
      events     <= 8'd0;
    end else begin
      if (state == IDLE && bus.i_bus_request) begin
        address    <= bus.i_bus_address;
        write      <= bus.i_bus_write;
        write_data <= bus.i_bus_write_data;
        strobe     <= mask_strobe;
        count      <= '0;
      end
      if (state == CMD || state == RESP) count <= count + CW'(1);
      if (resp_hs) begin
        read_data <= write ? '0 : bus.i_ext_resp_data;
        status    <= {bus.i_ext_resp_error, 1'b0};
      end
      if (abort) begin
        read_data <= '0;
        status    <= 2'b11;
        events    <= events + {7'd0, events != 8'hFF};
      end
    end
  end
  assign bus.o_bus_done       = state == DONE;
  assign bus.o_bus_read_data  = read_data;
  assign bus.o_bus_status     = status;
  assign bus.o_ext_valid      = state == CMD;
  assign bus.o_ext_address    = address;
  assign bus.o_ext_write      = write;
  assign bus.o_ext_write_data = write_data;
  assign bus.o_ext_strobe     = strobe;
  assign bus.o_busy           = state != IDLE;
  assign bus.o_timeout_events = events;
endmodule

// File: tb/tb_rggen_external_bus_bridge.sv
// tb_rggen_external_bus_bridge: table-driven and directed checks of the external bus bridge
module tb_rggen_external_bus_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass = 0;
  int   total = 0;
  rggen_external_bus_bridge_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) bus ();
  rggen_external_bus_bridge #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] mask;
    int          rdly;
    int          pdly;
    logic [31:0] rdata_in;
    logic        err;
    logic [3:0]  strobe;
    logic [31:0] rdata;
    logic [1:0]  status;
    int          lat;
  } vec_t;
  vec_t vecs[5];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic run(input vec_t v, input string tag);
    int  k = 0;
    int  r = 0;
    int  lat = 0;
    bit  stable = 1'b1;
    @(negedge clk);
    bus.i_bus_request    = 1'b1;
    bus.i_bus_address    = v.addr;
    bus.i_bus_write      = v.write;
    bus.i_bus_write_data = v.wdata;
    bus.i_bus_write_mask = v.mask;
    bus.i_ext_resp_data  = v.rdata_in;
    bus.i_ext_resp_error = v.err;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      bus.i_ext_ready      = 1'b0;
      bus.i_ext_resp_valid = 1'b0;
      if (bus.o_bus_done) begin
        lat = c;
        bus.i_bus_request = 1'b0;
      end else if (bus.o_ext_valid) begin
        k++;
        if (bus.o_ext_address !== v.addr || bus.o_ext_write !== v.write ||
            bus.o_ext_write_data !== v.wdata || bus.o_ext_strobe !== v.strobe) stable = 1'b0;
        bus.i_ext_ready = k > v.rdly;
      end else if (bus.o_busy) begin
        r++;
        bus.i_ext_resp_valid = r > v.pdly;
      end
    end
    bus.i_bus_request = 1'b0;
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " valid_cycles"}, k, v.rdly + 1);
    chk({tag, " ext_stable"}, stable, 1);
    chk({tag, " read_data"}, bus.o_bus_read_data, v.rdata);
    chk({tag, " status"}, bus.o_bus_status, v.status);
  endtask
  task automatic timeout_txn(output int k, output int lat);
    k = 0;
    lat = 0;
    @(negedge clk);
    bus.i_bus_request    = 1'b1;
    bus.i_bus_address    = 8'h40;
    bus.i_bus_write      = 1'b0;
    bus.i_bus_write_mask = 32'h0;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      @(negedge clk);
      bus.i_ext_ready      = 1'b0;
      bus.i_ext_resp_valid = 1'b0;
      if (bus.o_bus_done) lat = c;
      else if (bus.o_ext_valid) k++;
    end
    bus.i_bus_request = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int  k, lat;
    bit  quiet;
    vecs[0] = '{1'b0, 8'h84, 32'h0, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 4'b0000, 32'hDEADBEEF, 2'b00, 3};
    vecs[1] = '{1'b1, 8'h10, 32'h12345678, 32'h0000FF00, 5, 0, 32'hFFFFFFFF, 1'b0, 4'b0010, 32'h0, 2'b00, 8};
    vecs[2] = '{1'b0, 8'h20, 32'h0, 32'hFFFFFFFF, 1, 2, 32'hCAFEF00D, 1'b1, 4'b1111, 32'hCAFEF00D, 2'b10, 6};
    vecs[3] = '{1'b1, 8'hFF, 32'hA5A5A5A5, 32'hFF0000FF, 0, 3, 32'h11111111, 1'b1, 4'b1001, 32'h0, 2'b10, 6};
    vecs[4] = '{1'b0, 8'h33, 32'h0, 32'h00FF0000, 7, 0, 32'h0BADF00D, 1'b0, 4'b0100, 32'h0BADF00D, 2'b00, 10};
    bus.i_bus_request = 0; bus.i_bus_address = 0; bus.i_bus_write = 0;
    bus.i_bus_write_data = 0; bus.i_bus_write_mask = 0; bus.i_ext_ready = 0;
    bus.i_ext_resp_valid = 0; bus.i_ext_resp_data = 0; bus.i_ext_resp_error = 0;
    repeat (2) @(negedge clk);
    chk("reset busy", bus.o_busy, 0);
    chk("reset ext_valid", bus.o_ext_valid, 0);
    chk("reset done", bus.o_bus_done, 0);
    chk("reset status", bus.o_bus_status, 0);
    chk("reset read_data", bus.o_bus_read_data, 0);
    chk("reset events", bus.o_timeout_events, 0);
    chk("reset ext_fields", {bus.o_ext_address, bus.o_ext_write, bus.o_ext_write_data, bus.o_ext_strobe}, 0);
    rst = 1'b0;
    foreach (vecs[i]) run(vecs[i], $sformatf("vec%0d", i));
    chk("events before timeout", bus.o_timeout_events, 0);
    timeout_txn(k, lat);
    chk("timeout valid_cycles", k, 8);
    chk("timeout latency", lat, 9);
    chk("timeout status", bus.o_bus_status, 2'b11);
    chk("timeout read_data", bus.o_bus_read_data, 0);
    @(negedge clk);
    chk("timeout events", bus.o_timeout_events, 1);
    bus.i_ext_resp_valid = 1'b1;
    bus.i_ext_ready      = 1'b1;
    bus.i_ext_resp_data  = 32'h55;
    @(negedge clk);
    bus.i_ext_resp_valid = 1'b0;
    bus.i_ext_ready      = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (bus.o_busy || bus.o_bus_done || bus.o_ext_valid) quiet = 1'b0;
      @(negedge clk);
    end
    chk("stray resp ignored", quiet, 1);
    chk("stray status held", bus.o_bus_status, 2'b11);
    @(negedge clk);
    bus.i_bus_request = 1'b1;
    bus.i_bus_write   = 1'b0;
    @(negedge clk);
    chk("midrst ext_valid", bus.o_ext_valid, 1);
    bus.i_ext_ready = 1'b1;
    @(negedge clk);
    bus.i_ext_ready = 1'b0;
    chk("midrst in resp", {bus.o_busy, bus.o_ext_valid}, 2'b10);
    rst = 1'b1;
    bus.i_bus_request = 1'b0;
    @(negedge clk);
    chk("midrst after", {bus.o_busy, bus.o_ext_valid, bus.o_bus_done}, 3'b000);
    chk("midrst status cleared", bus.o_bus_status, 0);
    chk("midrst events cleared", bus.o_timeout_events, 0);
    rst = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.o_bus_done || bus.o_busy) quiet = 1'b0;
    end
    chk("midrst no done", quiet, 1);
    run(vecs[0], "after_reset");
    for (int n = 0; n < 255; n++) timeout_txn(k, lat);
    @(negedge clk);
    chk("events at 255", bus.o_timeout_events, 255);
    timeout_txn(k, lat);
    chk("sat timeout status", bus.o_bus_status, 2'b11);
    @(negedge clk);
    chk("events saturated", bus.o_timeout_events, 255);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
